// File: rtl/pipe_stage_reg_if.sv
// Pipeline stage register bus.
// Groups the upstream slot (controls, payload, PC, exception and delay-slot
// flag) with the registered downstream slot and the stall-cycle counter.
//   master : the environment; drives the upstream slot and reads the outputs
//   slave  : the stage register; reads the upstream slot and drives the outputs
interface pipe_stage_reg_if #(
    parameter int LANES = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    // upstream slot and controls
    logic                   stall;
    logic                   flush;
    logic                   valid_in;
    logic [LANES*WIDTH-1:0] data_in;
    logic [31:0]            pc_in;
    logic [4:0]             exc_in;
    logic [4:0]             exc_new;
    logic                   bd_in;
    // registered downstream slot
    logic                   valid_out;
    logic [LANES*WIDTH-1:0] data_out;
    logic [31:0]            pc_out;
    logic [4:0]             exc_out;
    logic                   bd_out;
    logic [CNT_W-1:0]       stall_cnt;

    modport master (
        output stall, flush, valid_in, data_in, pc_in, exc_in, exc_new, bd_in,
        input  valid_out, data_out, pc_out, exc_out, bd_out, stall_cnt
    );

    modport slave (
        input  stall, flush, valid_in, data_in, pc_in, exc_in, exc_new, bd_in,
        output valid_out, data_out, pc_out, exc_out, bd_out, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register with stall, flush and exception merging.
// Ports:
//   clk   : single clock, rising-edge
//   reset : asynchronous active-high reset, clears every output
//   bus   : pipe_stage_reg_if.slave -- upstream slot in, registered slot out,
//           plus a saturating count of honoured stall cycles
// Every output comes straight from a flop.
module pipe_stage_reg #(
    parameter int LANES = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    pipe_stage_reg_if.slave bus
);
    logic             valid_reg;
    logic [31:0]      pc_reg;
    logic [4:0]       exc_reg;
    logic             bd_reg;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [4:0]       exc_next;
    logic             hold;

    // Earliest-stage exception wins; a bubble never raises one.
    always_comb begin
        exc_next = 5'd0;
        if (bus.valid_in) begin
            exc_next = (bus.exc_in != 5'd0) ? bus.exc_in : bus.exc_new;
        end
    end

    // Flush overrides stall, so a stall is only honoured without flush.
    assign hold = bus.stall && !bus.flush;

    // Per-lane payload registers.
    logic [WIDTH-1:0] lane_reg [LANES];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    lane_reg[gi] <= '0;
                end else if (bus.flush) begin
                    lane_reg[gi] <= '0;
                end else if (!bus.stall) begin
                    lane_reg[gi] <= bus.data_in[gi*WIDTH +: WIDTH];
                end
            end
            assign bus.data_out[gi*WIDTH +: WIDTH] = lane_reg[gi];
        end
    endgenerate

    // Control/status fields. A flushed bubble still carries PC and BD so
    // interrupt entry has a correct EPC and delay-slot indication.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= 1'b0;
            pc_reg    <= 32'd0;
            exc_reg   <= 5'd0;
            bd_reg    <= 1'b0;
        end else if (bus.flush) begin
            valid_reg <= 1'b0;
            pc_reg    <= bus.pc_in;
            exc_reg   <= 5'd0;
            bd_reg    <= bus.bd_in;
        end else if (!bus.stall) begin
            valid_reg <= bus.valid_in;
            pc_reg    <= bus.pc_in;
            exc_reg   <= exc_next;
            bd_reg    <= bus.bd_in;
        end
    end

    // Saturating stall counter; flush edges leave it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else if (hold && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign bus.valid_out = valid_reg;
    assign bus.pc_out    = pc_reg;
    assign bus.exc_out   = exc_reg;
    assign bus.bd_out    = bd_reg;
    assign bus.stall_cnt = stall_cnt_reg;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a default-sized instance (a) and a
// narrow instance (b: LANES=1, WIDTH=8, CNT_W=3) for counter saturation.
module tb_pipe_stage_reg;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    pipe_stage_reg_if #(.LANES(4), .WIDTH(32), .CNT_W(16)) bus_a ();
    pipe_stage_reg_if #(.LANES(1), .WIDTH(8),  .CNT_W(3))  bus_b ();

    pipe_stage_reg #(.LANES(4), .WIDTH(32), .CNT_W(16)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    pipe_stage_reg #(.LANES(1), .WIDTH(8), .CNT_W(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic st, input logic fl, input logic vi,
                           input logic [127:0] d, input logic [31:0] pc,
                           input logic [4:0] ei, input logic [4:0] en, input logic bd);
        bus_a.stall    = st;
        bus_a.flush    = fl;
        bus_a.valid_in = vi;
        bus_a.data_in  = d;
        bus_a.pc_in    = pc;
        bus_a.exc_in   = ei;
        bus_a.exc_new  = en;
        bus_a.bd_in    = bd;
    endtask

    localparam logic [127:0] PAT = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] PAT2 = 128'hdeadbeef_cafef00d_01234567_89abcdef;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        drive_a(1'b0, 1'b0, 1'b0, 128'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        bus_b.stall    = 1'b0;
        bus_b.flush    = 1'b0;
        bus_b.valid_in = 1'b0;
        bus_b.data_in  = 8'h00;
        bus_b.pc_in    = 32'd0;
        bus_b.exc_in   = 5'd0;
        bus_b.exc_new  = 5'd0;
        bus_b.bd_in    = 1'b0;

        // Reset state, before any clock edge.
        #1 reset = 1'b1;
        #2;
        chk("rst_valid", 128'(bus_a.valid_out), 128'd0);
        chk("rst_data",  128'(bus_a.data_out),  128'd0);
        chk("rst_pc",    128'(bus_a.pc_out),    128'd0);
        chk("rst_exc",   128'(bus_a.exc_out),   128'd0);
        chk("rst_bd",    128'(bus_a.bd_out),    128'd0);
        chk("rst_cnt",   128'(bus_a.stall_cnt), 128'd0);
        step();
        reset = 1'b0;

        // Pass-through.
        drive_a(1'b0, 1'b0, 1'b1, PAT, 32'h0000_3000, 5'd0, 5'd0, 1'b0);
        step();
        chk("pass_data",  128'(bus_a.data_out),  PAT);
        chk("pass_pc",    128'(bus_a.pc_out),    128'h3000);
        chk("pass_valid", 128'(bus_a.valid_out), 128'd1);
        chk("pass_exc",   128'(bus_a.exc_out),   128'd0);

        // Exception priority.
        drive_a(1'b0, 1'b0, 1'b1, PAT, 32'h0000_3000, 5'd4, 5'd12, 1'b1);
        step();
        chk("exc_old_wins", 128'(bus_a.exc_out), 128'd4);
        chk("exc_bd",       128'(bus_a.bd_out),  128'd1);
        drive_a(1'b0, 1'b0, 1'b1, PAT, 32'h0000_3000, 5'd0, 5'd12, 1'b0);
        step();
        chk("exc_new_used", 128'(bus_a.exc_out), 128'd12);
        drive_a(1'b0, 1'b0, 1'b0, PAT2, 32'h0000_3040, 5'd0, 5'd12, 1'b0);
        step();
        chk("exc_invalid",   128'(bus_a.exc_out),   128'd0);
        chk("invalid_valid", 128'(bus_a.valid_out), 128'd0);
        chk("invalid_data",  128'(bus_a.data_out),  PAT2);
        chk("invalid_pc",    128'(bus_a.pc_out),    128'h3040);

        // Stall for three cycles while the upstream PC moves.
        drive_a(1'b0, 1'b0, 1'b1, PAT, 32'h0000_3004, 5'd0, 5'd0, 1'b0);
        step();
        chk("stall_pre_pc", 128'(bus_a.pc_out), 128'h3004);
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 1'b0, 1'b0, PAT2, 32'h0000_3100 + 32'(i), 5'd3, 5'd0, 1'b1);
            step();
        end
        chk("stall_pc",    128'(bus_a.pc_out),    128'h3004);
        chk("stall_cnt",   128'(bus_a.stall_cnt), 128'd3);
        chk("stall_valid", 128'(bus_a.valid_out), 128'd1);
        chk("stall_data",  128'(bus_a.data_out),  PAT);
        chk("stall_bd",    128'(bus_a.bd_out),    128'd0);

        // Flush together with stall.
        drive_a(1'b1, 1'b1, 1'b1, PAT2, 32'h0000_3008, 5'd10, 5'd0, 1'b1);
        step();
        chk("fl_valid", 128'(bus_a.valid_out), 128'd0);
        chk("fl_exc",   128'(bus_a.exc_out),   128'd0);
        chk("fl_data",  128'(bus_a.data_out),  128'd0);
        chk("fl_pc",    128'(bus_a.pc_out),    128'h3008);
        chk("fl_bd",    128'(bus_a.bd_out),    128'd1);
        chk("fl_cnt",   128'(bus_a.stall_cnt), 128'd3);

        // Capture, stall, then reset between edges.
        drive_a(1'b0, 1'b0, 1'b1, PAT2, 32'h0000_300c, 5'd0, 5'd7, 1'b1);
        step();
        drive_a(1'b1, 1'b0, 1'b1, PAT, 32'h0000_3200, 5'd0, 5'd0, 1'b0);
        step();
        chk("hold_valid", 128'(bus_a.valid_out), 128'd1);
        chk("hold_cnt",   128'(bus_a.stall_cnt), 128'd4);
        chk("hold_exc",   128'(bus_a.exc_out),   128'd7);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 128'(bus_a.valid_out), 128'd0);
        chk("arst_data",  128'(bus_a.data_out),  128'd0);
        chk("arst_pc",    128'(bus_a.pc_out),    128'd0);
        chk("arst_exc",   128'(bus_a.exc_out),   128'd0);
        chk("arst_bd",    128'(bus_a.bd_out),    128'd0);
        chk("arst_cnt",   128'(bus_a.stall_cnt), 128'd0);
        step();
        reset = 1'b0;
        drive_a(1'b0, 1'b0, 1'b1, PAT, 32'h0000_3010, 5'd0, 5'd0, 1'b0);
        step();
        chk("post_rst_pc",  128'(bus_a.pc_out),    128'h3010);
        chk("post_rst_cnt", 128'(bus_a.stall_cnt), 128'd0);
        drive_a(1'b0, 1'b0, 1'b0, 128'd0, 32'd0, 5'd0, 5'd0, 1'b0);

        // Narrow instance: pass-through, then saturating stall counter.
        bus_b.valid_in = 1'b1;
        bus_b.data_in  = 8'ha5;
        bus_b.pc_in    = 32'h0000_0040;
        step();
        chk("b_data",  128'(bus_b.data_out),  128'ha5);
        chk("b_valid", 128'(bus_b.valid_out), 128'd1);
        bus_b.stall   = 1'b1;
        bus_b.data_in = 8'h5a;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk($sformatf("b_cnt_%0d", i), 128'(bus_b.stall_cnt), 128'((i > 7) ? 7 : i));
        end
        chk("b_hold_data", 128'(bus_b.data_out), 128'ha5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
